load_store_buffer: RTL and testbench
====================================

// Module: load_store_buffer
// PURPOSE
//   In-order load/store queue; consumer end of the LS reservation station's issue interface.
//   Dispatch allocates entries in program order. The RS later supplies the effective address and store data, matched by ROB id.
//   The head entry is executed against the memory controller. The result is broadcast on the LS CDB (_cdb_ls_*).
// PARAMETERS
//   LSB_BITS  3          log2 of queue depth (DEPTH = 8 entries)
//   IO_BASE   32'h30000  addresses >= IO_BASE are MMIO; loads there wait for ROB head
// PORTS
//   clk_in         in   1   system clock
//   rst_in         in   1   synchronous active-high reset
//   rdy_in         in   1   global pause; low freezes all state, outputs hold
//   _clear         in   1   mispredict flush (synchronous, same effect as rst_in)
//   _dp_ready      in   1   dispatch allocates one entry this cycle
//   _dp_type       in   4   {is_store, funct3}: LB0 LH1 LW2 LBU4 LHU5; SB0 SH1 SW2
//   _dp_rob_id     in   5   ROB id of the allocated instruction
//   _lsb_full      out  1   count == DEPTH
//   _lsb_rs_ready  in   1   RS delivers resolved operands
//   _lsb_rob_id    in   5   ROB id being resolved (CAM key)
//   _lsb_st_value  in   32  store data (don't-care for loads)
//   _lsb_ptr_value in   32  effective address
//   _rob_head_id   in   5   ROB id currently at ROB head
//   _mem_req       out  1   memory request valid (level, held until _mem_done)
//   _mem_we        out  1   1 = write
//   _mem_addr      out  32  byte address
//   _mem_len       out  2   bytes-1 (0,1,3)
//   _mem_wdata     out  32  store data, low bytes significant
//   _mem_done      in   1   one-cycle completion pulse
//   _mem_rdata     in   32  raw load data, low bytes significant, valid with _mem_done
//   _cdb_ls_ready  out  1   one-cycle LS broadcast valid
//   _cdb_ls_rob_id out  5   broadcast ROB id
//   _cdb_ls_value  out  32  load result (extended); 0 for stores
// BEHAVIOUR
// - Storage: circular queue, head/tail ptrs (LSB_BITS wide, wrap modulo DEPTH), count (LSB_BITS+1).
//   Per entry: busy, type, rob_id, addr, sv, addr_ok.
// - Reset/_clear: count=0, head=tail=0, all busy/addr_ok=0, state IDLE.
//   All outputs 0 (_lsb_full=0). Any in-flight memory op is abandoned; a later _mem_done is ignored.
// - Allocation: _dp_ready writes entry[tail] with busy=1, addr_ok=0; tail++.
//   Dispatch must not assert _dp_ready while _lsb_full; if it does, the request is dropped.
// - Resolve: _lsb_rs_ready sets addr/sv and addr_ok=1 on the busy entry whose rob_id matches.
//   ROB ids are unique in the queue. No match: ignored. Takes effect the next cycle.
// - Head eligibility: busy && addr_ok, and:
//     store: rob_id == _rob_head_id;
//     load with addr >= IO_BASE: rob_id == _rob_head_id;
//     other load: unconditional.
// - FSM IDLE -> MEM -> BCAST -> IDLE:
//     IDLE: head eligible -> drive _mem_* registered, _mem_req=1 next cycle, go MEM.
//     MEM: hold all _mem_* stable. On _mem_done:
//       _mem_req=0;
//       latch value: LB/LH sign-extend, LBU/LHU zero-extend, LW as-is, store 0;
//       go BCAST.
//     BCAST: _cdb_ls_ready=1 for exactly one cycle with rob_id/value; pop head
//       (busy=0, head++); go IDLE.
// - Minimum latency: head eligible at cycle t -> _mem_req at t+1.
//   With _mem_done at t+k, _cdb_ls_ready is at t+k+1; the next op's _mem_req is no earlier than t+k+3.
// - Count: alloc only +1; pop only -1; alloc and pop in the same cycle: unchanged.
//   Full queue with pop and alloc in the same cycle is legal.
// - Resolve, alloc and pop in one cycle act on distinct entries; all three apply.
// - _mem_done outside MEM: ignored. rdy_in low: no state change, _mem_done ignored.
//   Memory controller holds done until rdy_in returns.
// - Wrap: tail 7 -> 0, head 7 -> 0; entry 0 is reused only after it is popped.
// TESTING
// - LW after reset: alloc {0,2} rob 3; resolve addr 0x100. -> _mem_req 1 cycle later, we=0, len=3;
//   done with rdata 0x80; -> _cdb_ls rob 3, value 0x80.
// - LB sign: rdata 0x000000F0 -> value 0xFFFFFFF0. LBU -> 0x000000F0. LHU 0x8001 -> 0x00008001.
// - SW gated: alloc {1,2} rob 5, addr 0x200, sv 0xDEAD. _rob_head_id=4 -> no req.
//   Head 5 -> req, we=1, wdata 0xDEAD; after done -> CDB rob 5, value 0.
// - MMIO load at addr 0x30000 waits for _rob_head_id match; a normal load behind it is not reordered.
// - Fill 8 entries -> _lsb_full=1. Pop and alloc in the same cycle -> full stays 1, tail wraps to 0.
//   Out-of-order resolve (rob 7 before rob 6) -> execution still in allocation order.
// - _clear in MEM: queue empty, _mem_req=0 next cycle. A stale _mem_done 2 cycles later gives no CDB.
//   rdy_in low for 3 cycles mid-MEM -> outputs frozen.

Source files
------------

// File: rtl/load_store_buffer.sv
// In-order load/store queue: entries are allocated at dispatch, resolved by ROB id from the RS,
// and executed one at a time from the head against the memory controller, then broadcast on the LS CDB.
module load_store_buffer #(
    parameter int          LSB_BITS = 3,
    parameter logic [31:0] IO_BASE  = 32'h30000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        _clear,
    input  logic        _dp_ready,
    input  logic [3:0]  _dp_type,
    input  logic [4:0]  _dp_rob_id,
    output logic        _lsb_full,
    input  logic        _lsb_rs_ready,
    input  logic [4:0]  _lsb_rob_id,
    input  logic [31:0] _lsb_st_value,
    input  logic [31:0] _lsb_ptr_value,
    input  logic [4:0]  _rob_head_id,
    output logic        _mem_req,
    output logic        _mem_we,
    output logic [31:0] _mem_addr,
    output logic [1:0]  _mem_len,
    output logic [31:0] _mem_wdata,
    input  logic        _mem_done,
    input  logic [31:0] _mem_rdata,
    output logic        _cdb_ls_ready,
    output logic [4:0]  _cdb_ls_rob_id,
    output logic [31:0] _cdb_ls_value
);

    localparam int                DEPTH      = 1 << LSB_BITS;
    localparam logic [LSB_BITS:0] FULL_COUNT = (LSB_BITS + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MEM   = 2'd1,
        BCAST = 2'd2
    } lsbState_e;

    lsbState_e r_state;
    lsbState_e w_nextState;

    logic [LSB_BITS-1:0] r_head;
    logic [LSB_BITS-1:0] r_tail;
    logic [LSB_BITS:0]   r_count;

    logic        r_busy   [DEPTH];
    logic        r_addrOk [DEPTH];
    logic [3:0]  r_type   [DEPTH];
    logic [4:0]  r_robId  [DEPTH];
    logic [31:0] r_addr   [DEPTH];
    logic [31:0] r_sv     [DEPTH];

    logic        r_memReq;
    logic        r_memWe;
    logic [31:0] r_memAddr;
    logic [1:0]  r_memLen;
    logic [31:0] r_memWdata;
    logic        r_cdbReady;
    logic [4:0]  r_cdbRobId;
    logic [31:0] r_cdbValue;

    logic             w_flush;
    logic             w_full;
    logic             w_alloc;
    logic             w_issue;
    logic             w_complete;
    logic             w_pop;
    logic             w_headEligible;
    logic [3:0]       w_headType;
    logic [4:0]       w_headRobId;
    logic [31:0]      w_headAddr;
    logic [31:0]      w_headSv;
    logic [1:0]       w_headLen;
    logic [31:0]      w_loadValue;
    logic [DEPTH-1:0] w_resolveHit;

    assign w_flush     = rst_in || _clear;
    assign w_full      = (r_count == FULL_COUNT);
    assign w_headType  = r_type[r_head];
    assign w_headRobId = r_robId[r_head];
    assign w_headAddr  = r_addr[r_head];
    assign w_headSv    = r_sv[r_head];
    assign w_headLen   = w_headType[1] ? 2'd3 : {1'b0, w_headType[0]};

    // A full queue still accepts dispatch when the head is retiring in the same cycle.
    assign w_alloc = _dp_ready && (!w_full || w_pop);

    // Stores and MMIO loads have side effects, so they only run once they are the oldest in the ROB.
    always_comb begin
        w_headEligible = 1'b0;
        if (r_busy[r_head] && r_addrOk[r_head]) begin
            if (w_headType[3] || (w_headAddr >= IO_BASE)) begin
                w_headEligible = (w_headRobId == _rob_head_id);
            end else begin
                w_headEligible = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_resolveHit[i] = _lsb_rs_ready && r_busy[i] && (r_robId[i] == _lsb_rob_id);
        end
    end

    always_comb begin
        w_loadValue = 32'd0;
        case (w_headType)
            4'h0:    w_loadValue = {{24{_mem_rdata[7]}}, _mem_rdata[7:0]};
            4'h1:    w_loadValue = {{16{_mem_rdata[15]}}, _mem_rdata[15:0]};
            4'h2:    w_loadValue = _mem_rdata;
            4'h4:    w_loadValue = {24'd0, _mem_rdata[7:0]};
            4'h5:    w_loadValue = {16'd0, _mem_rdata[15:0]};
            default: w_loadValue = 32'd0;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (w_flush) begin
            r_state <= IDLE;
        end else if (rdy_in) begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_issue     = 1'b0;
        w_complete  = 1'b0;
        w_pop       = 1'b0;
        if (rdy_in) begin
            case (r_state)
                IDLE: begin
                    if (w_headEligible) begin
                        w_issue     = 1'b1;
                        w_nextState = MEM;
                    end
                end
                MEM: begin
                    if (_mem_done) begin
                        w_complete  = 1'b1;
                        w_nextState = BCAST;
                    end
                end
                BCAST: begin
                    w_pop       = 1'b1;
                    w_nextState = IDLE;
                end
                default: w_nextState = IDLE;
            endcase
        end
    end

    // Pop is applied before alloc so that a full queue reusing the head slot keeps it busy.
    always_ff @(posedge clk_in) begin
        if (w_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_busy[i]   <= 1'b0;
                r_addrOk[i] <= 1'b0;
            end
        end else if (rdy_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_resolveHit[i]) begin
                    r_addrOk[i] <= 1'b1;
                end
            end
            if (w_pop) begin
                r_busy[r_head]   <= 1'b0;
                r_addrOk[r_head] <= 1'b0;
                r_head           <= r_head + 1'b1;
            end
            if (w_alloc) begin
                r_busy[r_tail]   <= 1'b1;
                r_addrOk[r_tail] <= 1'b0;
                r_tail           <= r_tail + 1'b1;
            end
            case ({w_alloc, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_resolveHit[i]) begin
                    r_addr[i] <= _lsb_ptr_value;
                    r_sv[i]   <= _lsb_st_value;
                end
            end
            if (w_alloc) begin
                r_type[r_tail]  <= _dp_type;
                r_robId[r_tail] <= _dp_rob_id;
            end
        end
    end

    // Memory and CDB outputs are registered; a flush abandons any request in flight.
    always_ff @(posedge clk_in) begin
        if (w_flush) begin
            r_memReq   <= 1'b0;
            r_memWe    <= 1'b0;
            r_memAddr  <= 32'd0;
            r_memLen   <= 2'd0;
            r_memWdata <= 32'd0;
            r_cdbReady <= 1'b0;
            r_cdbRobId <= 5'd0;
            r_cdbValue <= 32'd0;
        end else if (rdy_in) begin
            if (w_issue) begin
                r_memReq   <= 1'b1;
                r_memWe    <= w_headType[3];
                r_memAddr  <= w_headAddr;
                r_memLen   <= w_headLen;
                r_memWdata <= w_headSv;
            end
            if (w_complete) begin
                r_memReq   <= 1'b0;
                r_cdbReady <= 1'b1;
                r_cdbRobId <= w_headRobId;
                r_cdbValue <= w_loadValue;
            end
            if (w_pop) begin
                r_cdbReady <= 1'b0;
            end
        end
    end

    assign _lsb_full      = w_full;
    assign _mem_req       = r_memReq;
    assign _mem_we        = r_memWe;
    assign _mem_addr      = r_memAddr;
    assign _mem_len       = r_memLen;
    assign _mem_wdata     = r_memWdata;
    assign _cdb_ls_ready  = r_cdbReady;
    assign _cdb_ls_rob_id = r_cdbRobId;
    assign _cdb_ls_value  = r_cdbValue;

endmodule

// File: tb/tb_load_store_buffer.sv
// Directed bench for load_store_buffer: each scenario task drives the queue and checks
// the memory-side and CDB-side outputs against hand-computed values.
module tb_load_store_buffer;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        _clear;
    logic        _dp_ready;
    logic [3:0]  _dp_type;
    logic [4:0]  _dp_rob_id;
    logic        _lsb_full;
    logic        _lsb_rs_ready;
    logic [4:0]  _lsb_rob_id;
    logic [31:0] _lsb_st_value;
    logic [31:0] _lsb_ptr_value;
    logic [4:0]  _rob_head_id;
    logic        _mem_req;
    logic        _mem_we;
    logic [31:0] _mem_addr;
    logic [1:0]  _mem_len;
    logic [31:0] _mem_wdata;
    logic        _mem_done;
    logic [31:0] _mem_rdata;
    logic        _cdb_ls_ready;
    logic [4:0]  _cdb_ls_rob_id;
    logic [31:0] _cdb_ls_value;

    int checks;
    int passes;

    load_store_buffer dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        ._clear         (_clear),
        ._dp_ready      (_dp_ready),
        ._dp_type       (_dp_type),
        ._dp_rob_id     (_dp_rob_id),
        ._lsb_full      (_lsb_full),
        ._lsb_rs_ready  (_lsb_rs_ready),
        ._lsb_rob_id    (_lsb_rob_id),
        ._lsb_st_value  (_lsb_st_value),
        ._lsb_ptr_value (_lsb_ptr_value),
        ._rob_head_id   (_rob_head_id),
        ._mem_req       (_mem_req),
        ._mem_we        (_mem_we),
        ._mem_addr      (_mem_addr),
        ._mem_len       (_mem_len),
        ._mem_wdata     (_mem_wdata),
        ._mem_done      (_mem_done),
        ._mem_rdata     (_mem_rdata),
        ._cdb_ls_ready  (_cdb_ls_ready),
        ._cdb_ls_rob_id (_cdb_ls_rob_id),
        ._cdb_ls_value  (_cdb_ls_value)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic allocEntry(input logic [3:0] t, input logic [4:0] id);
        _dp_ready  = 1'b1;
        _dp_type   = t;
        _dp_rob_id = id;
        tick();
        _dp_ready  = 1'b0;
    endtask

    task automatic resolveEntry(input logic [4:0] id, input logic [31:0] a, input logic [31:0] sv);
        _lsb_rs_ready  = 1'b1;
        _lsb_rob_id    = id;
        _lsb_ptr_value = a;
        _lsb_st_value  = sv;
        tick();
        _lsb_rs_ready  = 1'b0;
    endtask

    task automatic waitReq(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (_mem_req === 1'b1) seen = 1'b1;
            else tick();
        end
    endtask

    task automatic pulseDone(input logic [31:0] rdata);
        _mem_done  = 1'b1;
        _mem_rdata = rdata;
        tick();
        _mem_done  = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
        checks++; if (_lsb_full !== 1'b0) $display("[TB] FAIL reset_full got %0b want 0", _lsb_full); else passes++;
        checks++; if (_mem_req !== 1'b0) $display("[TB] FAIL reset_req got %0b want 0", _mem_req); else passes++;
        checks++; if (_mem_addr !== 32'd0) $display("[TB] FAIL reset_addr got %h want 0", _mem_addr); else passes++;
        checks++; if (_cdb_ls_ready !== 1'b0) $display("[TB] FAIL reset_cdb got %0b want 0", _cdb_ls_ready); else passes++;
        checks++; if (_cdb_ls_value !== 32'd0) $display("[TB] FAIL reset_value got %h want 0", _cdb_ls_value); else passes++;
    endtask

    task automatic test_load_word();
        allocEntry(4'h2, 5'd3);
        resolveEntry(5'd3, 32'h100, 32'd0);
        checks++; if (_mem_req !== 1'b0) $display("[TB] FAIL lw_req_early got %0b want 0", _mem_req); else passes++;
        tick();
        checks++; if (_mem_req !== 1'b1) $display("[TB] FAIL lw_req got %0b want 1", _mem_req); else passes++;
        checks++; if (_mem_we !== 1'b0) $display("[TB] FAIL lw_we got %0b want 0", _mem_we); else passes++;
        checks++; if (_mem_len !== 2'd3) $display("[TB] FAIL lw_len got %0d want 3", _mem_len); else passes++;
        checks++; if (_mem_addr !== 32'h100) $display("[TB] FAIL lw_addr got %h want 00000100", _mem_addr); else passes++;
        pulseDone(32'h80);
        checks++; if (_mem_req !== 1'b0) $display("[TB] FAIL lw_req_drop got %0b want 0", _mem_req); else passes++;
        checks++; if (_cdb_ls_ready !== 1'b1) $display("[TB] FAIL lw_cdb got %0b want 1", _cdb_ls_ready); else passes++;
        checks++; if (_cdb_ls_rob_id !== 5'd3) $display("[TB] FAIL lw_rob got %0d want 3", _cdb_ls_rob_id); else passes++;
        checks++; if (_cdb_ls_value !== 32'h80) $display("[TB] FAIL lw_value got %h want 00000080", _cdb_ls_value); else passes++;
        tick();
        checks++; if (_cdb_ls_ready !== 1'b0) $display("[TB] FAIL lw_cdb_once got %0b want 0", _cdb_ls_ready); else passes++;
    endtask

    task automatic test_load_extend();
        logic [3:0]  extType [5] = '{4'h0, 4'h4, 4'h5, 4'h1, 4'h0};
        logic [31:0] extData [5] = '{32'h000000F0, 32'h000000F0, 32'h00008001, 32'h00008001, 32'h0000007F};
        logic [31:0] extWant [5] = '{32'hFFFFFFF0, 32'h000000F0, 32'h00008001, 32'hFFFF8001, 32'h0000007F};
        logic [1:0]  extLen  [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0};
        bit seen;
        for (int i = 0; i < 5; i++) begin
            allocEntry(extType[i], 5'(10 + i));
            resolveEntry(5'(10 + i), 32'h400 + 32'(4 * i), 32'd0);
            waitReq(6, seen);
            checks++; if (!seen) $display("[TB] FAIL ext%0d_req_timeout got 0 want 1", i); else passes++;
            checks++; if (_mem_len !== extLen[i]) $display("[TB] FAIL ext%0d_len got %0d want %0d", i, _mem_len, extLen[i]); else passes++;
            pulseDone(extData[i]);
            checks++; if (_cdb_ls_value !== extWant[i]) $display("[TB] FAIL ext%0d_value got %h want %h", i, _cdb_ls_value, extWant[i]); else passes++;
            tick();
        end
    endtask

    task automatic test_store_gated();
        _rob_head_id = 5'd4;
        allocEntry(4'hA, 5'd5);
        resolveEntry(5'd5, 32'h200, 32'hDEAD);
        tick();
        tick();
        tick();
        checks++; if (_mem_req !== 1'b0) $display("[TB] FAIL sw_gated got %0b want 0", _mem_req); else passes++;
        _rob_head_id = 5'd5;
        tick();
        checks++; if (_mem_req !== 1'b1) $display("[TB] FAIL sw_req got %0b want 1", _mem_req); else passes++;
        checks++; if (_mem_we !== 1'b1) $display("[TB] FAIL sw_we got %0b want 1", _mem_we); else passes++;
        checks++; if (_mem_wdata !== 32'hDEAD) $display("[TB] FAIL sw_wdata got %h want 0000dead", _mem_wdata); else passes++;
        checks++; if (_mem_addr !== 32'h200) $display("[TB] FAIL sw_addr got %h want 00000200", _mem_addr); else passes++;
        pulseDone(32'h12345678);
        checks++; if (_cdb_ls_rob_id !== 5'd5) $display("[TB] FAIL sw_rob got %0d want 5", _cdb_ls_rob_id); else passes++;
        checks++; if (_cdb_ls_value !== 32'd0) $display("[TB] FAIL sw_value got %h want 0", _cdb_ls_value); else passes++;
        tick();
        _rob_head_id = 5'd31;
    endtask

    task automatic test_mmio_order();
        _rob_head_id = 5'd0;
        allocEntry(4'h2, 5'd8);
        allocEntry(4'h2, 5'd9);
        resolveEntry(5'd8, 32'h30000, 32'd0);
        resolveEntry(5'd9, 32'h100, 32'd0);
        tick();
        tick();
        checks++; if (_mem_req !== 1'b0) $display("[TB] FAIL mmio_gated got %0b want 0", _mem_req); else passes++;
        _rob_head_id = 5'd8;
        tick();
        checks++; if (_mem_addr !== 32'h30000 || _mem_req !== 1'b1) $display("[TB] FAIL mmio_req got req %0b addr %h want 1 00030000", _mem_req, _mem_addr); else passes++;
        pulseDone(32'h11);
        checks++; if (_cdb_ls_rob_id !== 5'd8) $display("[TB] FAIL mmio_rob got %0d want 8", _cdb_ls_rob_id); else passes++;
        tick();
        checks++; if (_mem_req !== 1'b0) $display("[TB] FAIL next_req_early got %0b want 0", _mem_req); else passes++;
        tick();
        checks++; if (_mem_req !== 1'b1 || _mem_addr !== 32'h100) $display("[TB] FAIL next_req got req %0b addr %h want 1 00000100", _mem_req, _mem_addr); else passes++;
        pulseDone(32'h22);
        checks++; if (_cdb_ls_rob_id !== 5'd9 || _cdb_ls_value !== 32'h22) $display("[TB] FAIL next_cdb got rob %0d value %h want 9 00000022", _cdb_ls_rob_id, _cdb_ls_value); else passes++;
        tick();
        _rob_head_id = 5'd31;
    endtask

    task automatic test_full_wrap();
        bit seen;
        for (int r = 16; r < 24; r++) allocEntry(4'h2, 5'(r));
        checks++; if (_lsb_full !== 1'b1) $display("[TB] FAIL full_set got %0b want 1", _lsb_full); else passes++;
        resolveEntry(5'd16, 32'h1000, 32'd0);
        waitReq(6, seen);
        checks++; if (!seen || _mem_addr !== 32'h1000) $display("[TB] FAIL full_first got addr %h want 00001000", _mem_addr); else passes++;
        pulseDone(32'd16);
        checks++; if (_cdb_ls_rob_id !== 5'd16) $display("[TB] FAIL full_first_rob got %0d want 16", _cdb_ls_rob_id); else passes++;
        allocEntry(4'h2, 5'd24);
        checks++; if (_lsb_full !== 1'b1) $display("[TB] FAIL full_pop_alloc got %0b want 1", _lsb_full); else passes++;
        resolveEntry(5'd18, 32'h1008, 32'd0);
        tick();
        tick();
        checks++; if (_mem_req !== 1'b0) $display("[TB] FAIL ooo_gated got %0b want 0", _mem_req); else passes++;
        resolveEntry(5'd17, 32'h1004, 32'd0);
        for (int r = 17; r < 19; r++) begin
            waitReq(6, seen);
            checks++; if (!seen || _mem_addr !== 32'h1000 + 32'(4 * (r - 16))) $display("[TB] FAIL ooo_addr%0d got %h want %h", r, _mem_addr, 32'h1000 + 32'(4 * (r - 16))); else passes++;
            pulseDone(32'(r));
            checks++; if (_cdb_ls_rob_id !== 5'(r)) $display("[TB] FAIL ooo_rob%0d got %0d want %0d", r, _cdb_ls_rob_id, r); else passes++;
            tick();
        end
        for (int r = 19; r < 25; r++) resolveEntry(5'(r), 32'h1000 + 32'(4 * (r - 16)), 32'd0);
        for (int r = 19; r < 25; r++) begin
            waitReq(6, seen);
            checks++; if (!seen || _mem_addr !== 32'h1000 + 32'(4 * (r - 16))) $display("[TB] FAIL drain_addr%0d got %h want %h", r, _mem_addr, 32'h1000 + 32'(4 * (r - 16))); else passes++;
            pulseDone(32'(r));
            checks++; if (_cdb_ls_rob_id !== 5'(r) || _cdb_ls_value !== 32'(r)) $display("[TB] FAIL drain_cdb%0d got rob %0d value %h want %0d", r, _cdb_ls_rob_id, _cdb_ls_value, r); else passes++;
            tick();
        end
        checks++; if (_lsb_full !== 1'b0) $display("[TB] FAIL full_drained got %0b want 0", _lsb_full); else passes++;
    endtask

    task automatic test_clear_in_mem();
        bit seen;
        allocEntry(4'h2, 5'd2);
        resolveEntry(5'd2, 32'h300, 32'd0);
        waitReq(6, seen);
        checks++; if (!seen) $display("[TB] FAIL clr_req_timeout got 0 want 1"); else passes++;
        _clear = 1'b1;
        tick();
        _clear = 1'b0;
        checks++; if (_mem_req !== 1'b0) $display("[TB] FAIL clr_req got %0b want 0", _mem_req); else passes++;
        tick();
        pulseDone(32'h55);
        checks++; if (_cdb_ls_ready !== 1'b0) $display("[TB] FAIL clr_stale_cdb got %0b want 0", _cdb_ls_ready); else passes++;
        tick();
        checks++; if (_cdb_ls_ready !== 1'b0 || _mem_req !== 1'b0) $display("[TB] FAIL clr_quiet got cdb %0b req %0b want 0 0", _cdb_ls_ready, _mem_req); else passes++;
        allocEntry(4'h2, 5'd4);
        resolveEntry(5'd4, 32'h500, 32'd0);
        waitReq(6, seen);
        checks++; if (!seen || _mem_addr !== 32'h500) $display("[TB] FAIL clr_empty got addr %h want 00000500", _mem_addr); else passes++;
        pulseDone(32'h44);
        checks++; if (_cdb_ls_rob_id !== 5'd4) $display("[TB] FAIL clr_next_rob got %0d want 4", _cdb_ls_rob_id); else passes++;
        tick();
    endtask

    task automatic test_pause();
        bit seen;
        allocEntry(4'h2, 5'd6);
        resolveEntry(5'd6, 32'h600, 32'd0);
        waitReq(6, seen);
        checks++; if (!seen) $display("[TB] FAIL pause_req_timeout got 0 want 1"); else passes++;
        rdy_in = 1'b0;
        tick();
        tick();
        _mem_done  = 1'b1;
        _mem_rdata = 32'h99;
        tick();
        checks++; if (_mem_req !== 1'b1 || _mem_addr !== 32'h600) $display("[TB] FAIL pause_hold got req %0b addr %h want 1 00000600", _mem_req, _mem_addr); else passes++;
        checks++; if (_cdb_ls_ready !== 1'b0) $display("[TB] FAIL pause_done_ignored got %0b want 0", _cdb_ls_ready); else passes++;
        rdy_in = 1'b1;
        tick();
        _mem_done = 1'b0;
        checks++; if (_cdb_ls_ready !== 1'b1 || _cdb_ls_value !== 32'h99) $display("[TB] FAIL pause_resume got cdb %0b value %h want 1 00000099", _cdb_ls_ready, _cdb_ls_value); else passes++;
        rdy_in = 1'b0;
        tick();
        tick();
        checks++; if (_cdb_ls_ready !== 1'b1) $display("[TB] FAIL pause_bcast_hold got %0b want 1", _cdb_ls_ready); else passes++;
        rdy_in = 1'b1;
        tick();
        checks++; if (_cdb_ls_ready !== 1'b0) $display("[TB] FAIL pause_bcast_end got %0b want 0", _cdb_ls_ready); else passes++;
    endtask

    initial begin
        checks         = 0;
        passes         = 0;
        rst_in         = 1'b1;
        rdy_in         = 1'b1;
        _clear         = 1'b0;
        _dp_ready      = 1'b0;
        _dp_type       = 4'h0;
        _dp_rob_id     = 5'd0;
        _lsb_rs_ready  = 1'b0;
        _lsb_rob_id    = 5'd0;
        _lsb_st_value  = 32'd0;
        _lsb_ptr_value = 32'd0;
        _rob_head_id   = 5'd31;
        _mem_done      = 1'b0;
        _mem_rdata     = 32'd0;

        test_reset();
        test_load_word();
        test_load_extend();
        test_store_gated();
        test_mmio_order();
        test_full_wrap();
        test_clear_in_mem();
        test_pause();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
